booth_multiplier_seq: RTL

BOOTH_MULTIPLIER_SEQ -- requirements
Module: booth_multiplier_seq

---
 rtl/booth_multiplier_seq_if.sv | 21 ++
 rtl/booth_multiplier_seq.sv | 109 ++++++++++
 2 files changed

// File: rtl/booth_multiplier_seq_if.sv
// Operand/result bundle for the sequential Booth multiplier.
// The master drives the request and operands; the slave returns status and product.
interface booth_multiplier_seq_if;
  logic              start;
  logic signed [7:0] A;
  logic signed [7:0] B;
  logic              busy;
  logic              done;
  logic [15:0]       product;
  logic              valid;

  modport master (
    output start, A, B,
    input  busy, done, product, valid
  );

  modport slave (
    input  start, A, B,
    output busy, done, product, valid
  );
endinterface

// File: rtl/booth_multiplier_seq.sv
// Sequential radix-2 Booth multiplier: 8x8 signed operands, one Booth
// iteration per clock, 16-bit signed product. A 9-bit accumulator keeps the
// add/subtract exact even for a multiplicand of -128.
module booth_multiplier_seq (
  input  logic                  clk,
  input  logic                  rst,
  booth_multiplier_seq_if.slave bus
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [8:0]  m_q, m_d;
  logic [8:0]  acc_q, acc_d;
  logic [7:0]  q_q, q_d;
  logic        q1_q, q1_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] product_q, product_d;
  logic        done_q, done_d;
  logic        valid_q, valid_d;

  // Accumulator after the Booth add/subtract, and {Acc,Q,Q_1} after the shift.
  logic [8:0]  sum;
  logic [17:0] shift_vec;

  // Next-state logic: operand capture in IDLE, one Booth step per cycle in RUN.
  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    acc_d     = acc_q;
    q_d       = q_q;
    q1_d      = q1_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    done_d    = 1'b0;
    valid_d   = valid_q;
    sum       = acc_q;
    shift_vec = '0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          m_d     = {bus.A[7], bus.A};
          acc_d   = '0;
          q_d     = bus.B;
          q1_d    = 1'b0;
          cnt_d   = 4'd8;
          state_d = RUN;
        end
      end

      RUN: begin
        case ({q_q[0], q1_q})
          2'b01:   sum = acc_q + m_q;
          2'b10:   sum = acc_q - m_q;
          default: sum = acc_q;
        endcase
        // Arithmetic right shift of {sum, Q, Q_1}: sign bit replicated, Q_1 falls off.
        shift_vec = {sum[8], sum, q_q};
        acc_d     = shift_vec[17:9];
        q_d       = shift_vec[8:1];
        q1_d      = shift_vec[0];
        cnt_d     = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          product_d = {shift_vec[16:9], shift_vec[8:1]};
          done_d    = 1'b1;
          valid_d   = 1'b1;
          state_d   = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous reset clearing every datapath register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      m_q       <= '0;
      acc_q     <= '0;
      q_q       <= '0;
      q1_q      <= 1'b0;
      cnt_q     <= '0;
      product_q <= '0;
      done_q    <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      acc_q     <= acc_d;
      q_q       <= q_d;
      q1_q      <= q1_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      done_q    <= done_d;
      valid_q   <= valid_d;
    end
  end

  assign bus.busy    = (state_q == RUN);
  assign bus.done    = done_q;
  assign bus.product = product_q;
  assign bus.valid   = valid_q;

endmodule
